pixel_window_3x3: RTL and testbench
===================================

PIXEL_WINDOW_3X3 -- requirements
Module: pixel_window_3x3

Interface
REQ-001 Parameter IMG_WIDTH, default 320, pixels per line (>= 3).
REQ-002 Parameter IMG_HEIGHT, default 240, lines per frame (>= 3).
REQ-003 Parameter DATA_W, default 12, pixel width in bits (RGB444).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pixel_valid  input  1  pixel_in carries a pixel this cycle; accepted unconditionally (no backpressure).
REQ-007 sof  input  1  start of frame; qualified by pixel_valid; marks the current pixel as (row 0, col 0).
REQ-008 pixel_in  input  DATA_W  incoming raster-order pixel.
REQ-009 window_out  output  9*DATA_W  3x3 neighbourhood; element k = 3*r + c at bits [DATA_W*k +: DATA_W]; r=0 is the oldest row, c=0 the oldest column.
REQ-010 window_valid  output  1  window_out holds a complete in-frame window this cycle.
REQ-011 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-012 Block SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1), both advancing only on accepted pixels.
REQ-013 On an accepted pixel, col SHALL increment; at IMG_WIDTH-1 it SHALL wrap to 0 and row SHALL increment; at (IMG_HEIGHT-1, IMG_WIDTH-1) both SHALL wrap to 0.
REQ-014 An accepted pixel with sof=1 SHALL be treated as (0,0) regardless of counter state; the counters then advance to (0,1).
REQ-015 Block SHALL hold two line buffers of IMG_WIDTH x DATA_W containing the previous two lines, indexed by col.
REQ-016 On each accepted pixel at (R,C), the window SHALL shift one column: new column = {line R-2 col C, line R-1 col C, pixel_in} in rows r=0,1,2.
REQ-017 Output latency SHALL be exactly one cycle: window_out/window_valid are registered and reflect the pixel accepted on the previous edge.
REQ-018 window_valid SHALL be 1 iff the previous cycle accepted a pixel with R >= 2 and C >= 2; the window then covers rows R-2..R and columns C-2..C, centre k=4 = (R-1,C-1), k=8 = (R,C).
REQ-019 Windows spanning a line boundary (C < 2) or the top of a frame (R < 2) SHALL NOT be flagged valid; no border padding is generated.
REQ-020 Each frame SHALL yield exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) window_valid pulses.
REQ-021 When pixel_valid=0, counters, line buffers and window registers SHALL hold, and window_valid SHALL be 0 on the next cycle.
REQ-022 frame_done SHALL pulse one cycle after the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted, coincident with that pixel's window_valid.
REQ-023 An sof arriving mid-frame SHALL abort the frame: no frame_done for it, and window_valid SHALL stay 0 until row >= 2 of the new frame.
REQ-024 Pixel data SHALL pass unmodified; no arithmetic is applied to pixel values.

Reset
REQ-025 While reset is high: col=0, row=0, window_out=0, window_valid=0, frame_done=0, asynchronously.
REQ-026 Line buffer contents need not be reset; by REQ-018 stale data SHALL never appear in a valid window.
REQ-027 After reset deasserts, the first accepted pixel SHALL be treated as (0,0) whether or not sof is set.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3, DATA_W=12, pixel value = 16*row + col)
REQ-028 Stream one full frame with sof on the first pixel and pixel_valid continuous -> exactly 2 window_valid pulses, one cycle after pixels (2,2) and (2,3); first window k0=0x000, k4=0x011, k8=0x022; second window k0=0x001, k8=0x023; frame_done coincident with the second.
REQ-029 Same frame with pixel_valid deasserted for 3 cycles before pixel (2,3) -> window_valid low during the gap; second window identical to REQ-028; frame_done one cycle after (2,3) is accepted.
REQ-030 Two back-to-back frames, sof only on the first -> counters wrap; second frame yields the same 2 windows and a second frame_done.
REQ-031 sof asserted at pixel (1,2) of a frame -> no window_valid until new-frame pixel (2,2); its window k0=0x000 of the new frame; no frame_done for the aborted frame.
REQ-032 Reset asserted asynchronously mid-frame at (2,1) -> all outputs 0 immediately; restart without sof -> first pixel treated as (0,0); 2 windows per frame thereafter.

Source files
------------

// File: rtl/pixel_window_3x3.sv
// -----------------------------------------------------------------------------
// pixel_window_3x3
//
// Builds a sliding 3x3 pixel neighbourhood from a raster-order pixel stream.
// Two line buffers hold the previous two lines. Each accepted pixel shifts one
// new column into a 3x3 register window. A window is flagged valid only when
// it lies entirely inside the frame: no border padding is generated.
//
// Parameters
//   IMG_WIDTH    pixels per line (>= 3)
//   IMG_HEIGHT   lines per frame (>= 3)
//   DATA_W       pixel width in bits
//
// Ports
//   clk           system clock; all logic is on the rising edge
//   reset         asynchronous, active-high reset
//   pixel_valid   pixel_in carries a pixel this cycle (there is no backpressure)
//   sof           start of frame, qualified by pixel_valid; forces (row 0, col 0)
//   pixel_in      incoming pixel
//   window_out    3x3 window; element k = 3*r + c sits at [DATA_W*k +: DATA_W]
//                 r = 0 is the oldest row and c = 0 is the oldest column
//   window_valid  window_out holds a complete in-frame window this cycle
//   frame_done    one-cycle pulse after the last pixel of a frame is accepted
// -----------------------------------------------------------------------------
module pixel_window_3x3 #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int DATA_W     = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pixel_valid,
  input  logic                  sof,
  input  logic [DATA_W-1:0]     pixel_in,
  output logic [9*DATA_W-1:0]   window_out,
  output logic                  window_valid,
  output logic                  frame_done
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  // Position counters: they point at the next pixel expected.
  logic [COL_W-1:0] col, cur_col, col_next;
  logic [ROW_W-1:0] row, cur_row, row_next;

  // Line buffers: line_m1 holds line R-1 and line_m2 holds line R-2.
  logic [DATA_W-1:0] line_m1 [IMG_WIDTH];
  logic [DATA_W-1:0] line_m2 [IMG_WIDTH];

  logic [DATA_W-1:0]   tap_m1, tap_m2;
  logic [9*DATA_W-1:0] window_q, window_next;
  logic                last_col, last_row, in_window;

  // Position of the pixel being accepted. An sof pixel is always (0,0),
  // whatever the counters say. This also aborts a frame that is in progress.
  always_comb begin
    // NOTE: every signal written here is given a value first. No path is
    // left unassigned, so no latch is inferred.
    cur_col   = sof ? '0 : col;
    cur_row   = sof ? '0 : row;
    last_col  = (cur_col == COL_W'(IMG_WIDTH - 1));
    last_row  = (cur_row == ROW_W'(IMG_HEIGHT - 1));
    in_window = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));

    col_next = cur_col + COL_W'(1);
    row_next = cur_row;
    if (last_col) begin
      col_next = '0;
      row_next = last_row ? '0 : cur_row + ROW_W'(1);
    end
  end

  // Old contents of the two line buffers at the current column.
  assign tap_m1 = line_m1[cur_col];
  assign tap_m2 = line_m2[cur_col];

  // Shift the window one column left within each row. The new column
  // {line R-2, line R-1, pixel_in} enters at c = 2.
  always_comb begin
    window_next = window_q;
    for (int r = 0; r < 3; r++) begin
      window_next[DATA_W*(3*r+0) +: DATA_W] = window_q[DATA_W*(3*r+1) +: DATA_W];
      window_next[DATA_W*(3*r+1) +: DATA_W] = window_q[DATA_W*(3*r+2) +: DATA_W];
    end
    window_next[DATA_W*2 +: DATA_W] = tap_m2;
    window_next[DATA_W*5 +: DATA_W] = tap_m1;
    window_next[DATA_W*8 +: DATA_W] = pixel_in;
  end

  // Counters, window registers and output flags.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples the values from before the edge, which avoids races
    // between processes.
    if (reset) begin
      col          <= '0;
      row          <= '0;
      window_q     <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else if (pixel_valid) begin
      col          <= col_next;
      row          <= row_next;
      window_q     <= window_next;
      window_valid <= in_window;
      frame_done   <= last_row && last_col;
    end else begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end
  end

  // Line buffer storage.
  // NOTE: the line buffers have no reset, so they can map onto plain RAM.
  // A line is always rewritten within the current frame before it can reach
  // a valid window, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      line_m2[cur_col] <= tap_m1;
      line_m1[cur_col] <= pixel_in;
    end
  end

  assign window_out = window_q;

endmodule

// File: tb/tb_pixel_window_3x3.sv
// -----------------------------------------------------------------------------
// tb_pixel_window_3x3
//
// Self-checking bench for pixel_window_3x3 with IMG_WIDTH=4, IMG_HEIGHT=3 and
// DATA_W=12. Each pixel value is 16*row + col, in frame coordinates.
// When the bench drives a pixel whose window lies fully in the frame, it
// pushes the expected window and frame_done onto a scoreboard queue. The
// monitor pops that entry when window_valid rises.
// -----------------------------------------------------------------------------
module tb_pixel_window_3x3;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 12;

  typedef struct {
    logic [9*DW-1:0] win;
    logic            fd;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              pixel_valid;
  logic              sof;
  logic [DW-1:0]     pixel_in;
  logic [9*DW-1:0]   window_out;
  logic              window_valid;
  logic              frame_done;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   valid_cnt = 0;
  int   fd_cnt    = 0;

  pixel_window_3x3 #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DATA_W    (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_valid (pixel_valid),
    .sof         (sof),
    .pixel_in    (pixel_in),
    .window_out  (window_out),
    .window_valid(window_valid),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9*DW-1:0] obs,
                       input logic [9*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Window for the pixel at (r_c, c_c): rows r_c-2..r_c, cols c_c-2..c_c.
  function automatic logic [9*DW-1:0] model_win(input int r_c, input int c_c);
    logic [9*DW-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[DW*(3*r+c) +: DW] = DW'(16*(r_c-2+r) + (c_c-2+c));
    return w;
  endfunction

  task automatic drive_pixel(input int r, input int c, input bit s);
    exp_t e;
    @(negedge clk);
    pixel_valid = 1'b1;
    sof         = s;
    pixel_in    = DW'(16*r + c);
    if (r >= 2 && c >= 2) begin
      e.win = model_win(r, c);
      e.fd  = (r == H-1) && (c == W-1);
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pixel_valid = 1'b0;
      sof         = 1'b0;
    end
  endtask

  // Drain the pipeline, then check the window and frame_done counts for
  // the step and confirm that every expected window arrived.
  task automatic end_step(input string name, input int exp_windows, input int exp_fd);
    idle(3);
    check({name, "_windows"}, 108'(valid_cnt), 108'(exp_windows));
    check({name, "_frame_done"}, 108'(fd_cnt), 108'(exp_fd));
    check({name, "_sb_empty"}, 108'(sb.size()), 108'(0));
    valid_cnt = 0;
    fd_cnt    = 0;
  endtask

  // Monitor: samples outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (frame_done) fd_cnt++;
      if (window_valid) begin
        valid_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_window_valid", 108'(window_valid), 108'(0));
        end else begin
          e = sb.pop_front();
          check("window", window_out, e.win);
          check("frame_done_with_window", 108'(frame_done), 108'(e.fd));
        end
      end else if (frame_done) begin
        check("frame_done_without_window", 108'(frame_done), 108'(0));
      end
    end
  end

  initial begin
    reset       = 1'b1;
    pixel_valid = 1'b0;
    sof         = 1'b0;
    pixel_in    = '0;

    // Reset state
    #12;
    check("reset_window_out", window_out, '0);
    check("reset_window_valid", 108'(window_valid), 108'(0));
    check("reset_frame_done", 108'(frame_done), 108'(0));
    @(negedge clk);
    reset = 1'b0;

    // One frame, continuous valid, sof on the first pixel
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        drive_pixel(r, c, (r == 0 && c == 0));
    end_step("single_frame", 2, 1);

    // The same frame with a 3-cycle gap before pixel (2,3)
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (r == 2 && c == 3) idle(3);
        drive_pixel(r, c, (r == 0 && c == 0));
      end
    end_step("gap_frame", 2, 1);

    // Two back-to-back frames with sof only on the first
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          drive_pixel(r, c, (f == 0 && r == 0 && c == 0));
    end_step("back_to_back", 4, 2);

    // A mid-frame sof at (1,2) aborts the frame; the new frame runs in full
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++) begin
        if (r == 1 && c == 2) break;
        drive_pixel(r, c, (r == 0 && c == 0));
      end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        drive_pixel(r, c, (r == 0 && c == 0));
    end_step("abort_frame", 2, 1);

    // Asynchronous reset mid-frame after (2,1); restart without sof
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (r == 2 && c == 2) break;
        drive_pixel(r, c, (r == 0 && c == 0));
      end
    @(negedge clk);
    pixel_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_reset_window_out", window_out, '0);
    check("async_reset_window_valid", 108'(window_valid), 108'(0));
    check("async_reset_frame_done", 108'(frame_done), 108'(0));
    @(negedge clk);
    reset = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          drive_pixel(r, c, 1'b0);
    end_step("after_reset", 4, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
